mc_datapath_hs: RTL and testbench
=================================

// Module: mc_datapath_hs
// PURPOSE
//  Parametrised multicycle MIPS datapath with a memory request/ready handshake. Holds PC, IR, MDR, A, B and ALUOut, plus a 32-entry register file.
//  Sits between the main controller FSM, the external ALU/ALU controller and a shared instruction/data memory that may insert wait states.
//  Adds over the previous datapath: memory stall support, bne, jr, jal link writeback and a stall-cycle counter.
// PARAMETERS
//  ADDR_W    16     memory/PC address width (bits); 8..32
//  DATA_W    32     data/register width; fixed at 32 for MIPS ISA, kept for the regfile/bus
//  RESET_PC  0      PC value loaded on reset; ADDR_W bits, word aligned
//  CNT_W     16     width of the stall-cycle counter
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  PCWrite        in   1       unconditional PC update
//  PCWriteCond    in   1       conditional (branch) PC update
//  BranchNE       in   1       1: branch when !zero (bne); 0: branch when zero (beq)
//  PCSource       in   2       00 aluResult, 01 aluOut, 10 jump target, 11 A (jr)
//  IorD           in   1       0: address = PC; 1: address = aluOut[ADDR_W-1:0]
//  MemRead        in   1       memory read requested this state
//  MemWrite       in   1       memory write requested this state
//  IRWrite        in   1       load IR from read data
//  RegWrite       in   1       register file write
//  RegDst         in   2       00 rt, 01 rd, 10 r31, 11 reserved (treated as rt)
//  MemToReg       in   2       00 aluOut, 01 MDR, 10 PC zero-extended (link), 11 = 00
//  ALUSrcA        in   1       0: PC zero-extended; 1: A
//  ALUSrcB        in   2       00 B, 01 4, 10 sext(imm), 11 sext(imm)<<2
//  zero           in   1       ALU zero flag
//  aluResult      in   DATA_W  ALU result, combinational
//  mem_ready      in   1       memory completes the current request this cycle
//  mem_rdata      in   DATA_W  read data, valid when mem_ready
//  op             out  6       IR[31:26]
//  funct          out  6       IR[5:0]
//  aluParamData1  out  DATA_W  ALU operand A
//  aluParamData2  out  DATA_W  ALU operand B
//  mem_req        out  1       request outstanding
//  mem_we         out  1       1 = write request
//  mem_addr       out  ADDR_W  request address
//  mem_wdata      out  DATA_W  write data (= B register)
//  stall          out  1       controller must hold its state and all control inputs
//  stall_cnt      out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: PC=RESET_PC; IR, MDR, A, B, aluOut, all registers = 0; FSM=IDLE; mem_req=0, mem_we=0, stall=0, stall_cnt=0.
//    Applies immediately (asynchronous), including mid-request; any outstanding request is abandoned.
//  Memory FSM:
//    IDLE:
//      - MemRead|MemWrite: mem_req=1 in the same cycle (combinational); mem_addr, mem_we and mem_wdata driven from the live mux.
//      - mem_ready=1 the same cycle: zero-wait completion, stay IDLE.
//      - Otherwise latch addr, we and wdata; go to WAIT.
//    WAIT:
//      - mem_req=1 with the latched addr, we and wdata, regardless of control inputs.
//      - mem_ready=1: completion, go to IDLE.
//  stall = mem_req & ~mem_ready.
//    While stall=1: PC, IR, MDR, A, B, aluOut and the register file hold their values.
//    While stall=1: stall_cnt increments, saturating at all-ones.
//  Completion cycle (mem_ready=1):
//    - Read: MDR <= mem_rdata; IR <= mem_rdata if IRWrite.
//    - All other register updates of that cycle proceed normally.
//  Without a memory request, MDR <= mem_rdata every cycle is NOT performed; MDR changes only on read completion.
//  Unstalled cycles:
//    - A, B load the regfile read ports (rs, rt), 1-cycle latency.
//    - aluOut <= aluResult.
//  PC write enable = (PCWrite | (PCWriteCond & (zero ^ BranchNE))) & ~stall.
//  Jump target = {IR[25:0],2'b00} truncated to ADDR_W; jr uses A[ADDR_W-1:0].
//  Register file:
//    - r0 reads 0; writes to r0 are dropped.
//    - A write and a read of the same register in one cycle: the read returns the old value.
//  Width rules: PC zero-extended to DATA_W for ALU operand A and for link; aluOut truncated to ADDR_W for the address.
//  MemRead and MemWrite both high: treated as a write.
// TESTING
//  1. Reset mid-WAIT (MemRead, IorD=0, mem_ready=0 for 2 cycles, then reset) -> mem_req=0, PC=RESET_PC, stall=0 at once.
//  2. Fetch with 3 wait states, mem_rdata=32'h8C220004 on the 4th cycle, IRWrite=1, PCWrite=1, aluResult=4
//     -> IR=8C220004 and PC=4 only after ready; stall high 3 cycles; stall_cnt=3.
//  3. beq with zero=0, then bne with zero=0, PCSource=01, aluOut=0x40 -> PC unchanged, then PC=0x40.
//  4. jal: IR=0x0C000010, PC=8, RegDst=10, MemToReg=10, PCSource=10 -> r31=8, PC=0x40.
//  5. Write r0 with 0xFFFFFFFF -> A reads 0; write r5 with 0x1234 and read r5 in the same cycle -> A=old, next cycle 0x1234.
//  6. Store sw with mem_ready delayed, control inputs changed during WAIT -> mem_addr, mem_we and mem_wdata stay at the issued values until ready.

Source files
------------

// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS datapath with a request/ready memory handshake.
// Memory wait states raise stall, which freezes every architectural register.
module mc_datapath_hs #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              BranchNE,
  input  logic [1:0]        PCSource,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              RegWrite,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        MemToReg,
  input  logic              ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic              zero,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] aluParamData1,
  output logic [DATA_W-1:0] aluParamData2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} mem_state_e;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0] rf_q [32];

  logic              req_raw;
  logic              we_raw;
  logic              live_req;
  logic [ADDR_W-1:0] live_addr;
  logic              rd_done;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] jump_target;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] sext_imm;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign pc_ext      = DATA_W'(pc_q);
  assign sext_imm    = DATA_W'(signed'(ir_q[15:0]));
  assign jump_target = ADDR_W'({ir_q[25:0], 2'b00});
  assign live_req    = MemRead | MemWrite;
  assign live_addr   = IorD ? alu_out_q[ADDR_W-1:0] : pc_q;

  // Memory handshake: the issue cycle drives the live mux, WAIT replays the latched request.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    req_raw   = 1'b0;
    we_raw    = MemWrite;
    mem_addr  = live_addr;
    mem_wdata = b_q;
    case (state_q)
      S_IDLE: begin
        req_raw = live_req;
        if (live_req && !mem_ready) begin
          state_d = S_WAIT;
          addr_d  = live_addr;
          we_d    = MemWrite;
          wdata_d = b_q;
        end
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        we_raw    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset also masks the request so a controller still asserting MemRead cannot leak one out.
  assign mem_req = req_raw & ~reset;
  assign mem_we  = we_raw & mem_req;
  assign stall   = mem_req & ~mem_ready;
  assign rd_done = mem_req & mem_ready & ~mem_we;

  always_comb begin
    aluParamData1 = ALUSrcA ? a_q : pc_ext;
    case (ALUSrcB)
      2'b00:   aluParamData2 = b_q;
      2'b01:   aluParamData2 = DATA_W'(4);
      2'b10:   aluParamData2 = sext_imm;
      default: aluParamData2 = sext_imm << 2;
    endcase
  end

  always_comb begin
    case (PCSource)
      2'b00:   pc_next = aluResult[ADDR_W-1:0];
      2'b01:   pc_next = alu_out_q[ADDR_W-1:0];
      2'b10:   pc_next = jump_target;
      default: pc_next = a_q[ADDR_W-1:0];
    endcase
    pc_en = (PCWrite | (PCWriteCond & (zero ^ BranchNE))) & ~stall;
    pc_d  = pc_en ? pc_next : pc_q;

    mdr_d = rd_done ? mem_rdata : mdr_q;
    ir_d  = (rd_done && IRWrite) ? mem_rdata : ir_q;

    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    if (!stall) begin
      a_d       = rf_q[ir_q[25:21]];
      b_d       = rf_q[ir_q[20:16]];
      alu_out_d = aluResult;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_comb begin
    case (RegDst)
      2'b01:   rf_waddr = ir_q[15:11];
      2'b10:   rf_waddr = 5'd31;
      default: rf_waddr = ir_q[20:16];
    endcase
    case (MemToReg)
      2'b01:   rf_wdata = mdr_q;
      2'b10:   rf_wdata = pc_ext;
      default: rf_wdata = alu_out_q;
    endcase
    // r0 is never written, so its reset value of zero is what every read sees.
    rf_we = RegWrite & ~stall & (rf_waddr != 5'd0);
  end

  // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: the register file must come out of reset all-zero, so it is built from resettable flops, not RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: fetch with wait states, branches, jal/jr,
// register-file hazards, held store requests and stall-counter saturation.
module tb_mc_datapath_hs;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W-1:0] RST_PC = 16'h0010;

  logic              clk = 1'b0;
  logic              reset;
  logic              PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
  logic              IRWrite, RegWrite, ALUSrcA, zero, mem_ready;
  logic [1:0]        PCSource, RegDst, MemToReg, ALUSrcB;
  logic [DATA_W-1:0] aluResult, mem_rdata;
  logic [5:0]        op, funct;
  logic [DATA_W-1:0] aluParamData1, aluParamData2, mem_wdata;
  logic              mem_req, mem_we, stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mc_datapath_hs #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .zero(zero), .aluResult(aluResult),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .op(op), .funct(funct), .aluParamData1(aluParamData1), .aluParamData2(aluParamData2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    PCWrite = 0; PCWriteCond = 0; BranchNE = 0; PCSource = 2'b00; IorD = 0;
    MemRead = 0; MemWrite = 0; IRWrite = 0; RegWrite = 0; RegDst = 2'b00;
    MemToReg = 2'b00; ALUSrcA = 0; ALUSrcB = 2'b00; zero = 0;
    aluResult = '0; mem_ready = 0; mem_rdata = 32'hDEADBEEF;
  endtask

  // Zero-wait instruction fetch that leaves the PC alone unless pc_val is applied via PCWrite.
  task automatic fetch(input logic [31:0] instr, input logic [31:0] alu_val, input logic do_pc);
    clr();
    MemRead = 1; IRWrite = 1; mem_ready = 1; mem_rdata = instr;
    aluResult = alu_val; PCWrite = do_pc;
    step();
    clr();
  endtask

  initial begin
    clr();
    reset = 1;
    MemRead = 1;
    #1;
    check("rst_req_masked", {31'b0, mem_req}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc", aluParamData1, 32'h0000_0010);
    check("rst_op", {26'b0, op}, 32'h0);
    check("rst_cnt", {28'b0, stall_cnt}, 32'h0);
    reset = 0;
    clr();

    // Fetch with three wait states.
    MemRead = 1; IRWrite = 1; PCWrite = 1; aluResult = 32'd4;
    #1;
    check("f_req", {31'b0, mem_req}, 32'h1);
    check("f_addr", {16'b0, mem_addr}, 32'h0010);
    check("f_we", {31'b0, mem_we}, 32'h0);
    check("f_stall", {31'b0, stall}, 32'h1);
    step();
    check("f_cnt1", {28'b0, stall_cnt}, 32'd1);
    check("f_pc_held", aluParamData1, 32'h0010);
    step();
    step();
    check("f_ir_held", {26'b0, op}, 32'h0);
    check("f_cnt3w", {28'b0, stall_cnt}, 32'd3);
    mem_ready = 1; mem_rdata = 32'h8C22_0004;
    #1;
    check("f_ready_nostall", {31'b0, stall}, 32'h0);
    step();
    clr();
    #1;
    check("f_pc4", aluParamData1, 32'd4);
    check("f_op", {26'b0, op}, 32'h23);
    check("f_funct", {26'b0, funct}, 32'h04);
    check("f_cnt3", {28'b0, stall_cnt}, 32'd3);
    check("f_idle_req", {31'b0, mem_req}, 32'h0);
    ALUSrcB = 2'b11;
    #1;
    check("sext_sh2", aluParamData2, 32'h10);
    ALUSrcB = 2'b01;
    #1;
    check("const4", aluParamData2, 32'd4);
    clr();

    // Reset in the middle of a WAIT.
    MemRead = 1;
    #1;
    check("w_addr_pc", {16'b0, mem_addr}, 32'h0004);
    step();
    step();
    check("w_cnt5", {28'b0, stall_cnt}, 32'd5);
    check("w_req", {31'b0, mem_req}, 32'h1);
    reset = 1;
    #1;
    check("mr_req", {31'b0, mem_req}, 32'h0);
    check("mr_stall", {31'b0, stall}, 32'h0);
    check("mr_cnt", {28'b0, stall_cnt}, 32'h0);
    check("mr_pc", aluParamData1, 32'h0010);
    check("mr_op", {26'b0, op}, 32'h0);
    reset = 0;
    clr();
    #1;
    check("mr_idle", {31'b0, mem_req}, 32'h0);
    step();

    // beq not taken, then bne taken to aluOut.
    aluResult = 32'h40;
    step();
    IorD = 1;
    #1;
    check("aluout_addr", {16'b0, mem_addr}, 32'h0040);
    IorD = 0; PCWriteCond = 1; BranchNE = 0; zero = 0; PCSource = 2'b01;
    step();
    check("beq_nt", aluParamData1, 32'h0010);
    BranchNE = 1;
    step();
    check("bne_t", aluParamData1, 32'h0040);

    // jal, then jr through r31.
    fetch(32'h0C00_0010, 32'd8, 1'b1);
    #1;
    check("jal_op", {26'b0, op}, 32'h03);
    check("jal_pc8", aluParamData1, 32'd8);
    RegWrite = 1; RegDst = 2'b10; MemToReg = 2'b10; PCSource = 2'b10; PCWrite = 1;
    step();
    clr();
    #1;
    check("jal_pc", aluParamData1, 32'h40);
    fetch(32'h03E0_0008, 32'h0, 1'b0);
    step();
    ALUSrcA = 1;
    #1;
    check("r31_link", aluParamData1, 32'd8);
    check("jr_funct", {26'b0, funct}, 32'h08);
    PCSource = 2'b11; PCWrite = 1;
    step();
    clr();
    #1;
    check("jr_pc", aluParamData1, 32'd8);

    // r0 writes are dropped.
    fetch(32'h0000_0020, 32'hFFFF_FFFF, 1'b0);
    RegWrite = 1; aluResult = 32'hFFFF_FFFF;
    step();
    clr();
    step();
    ALUSrcA = 1;
    #1;
    check("r0_a", aluParamData1, 32'h0);
    check("r0_b", aluParamData2, 32'h0);

    // Same-cycle write/read of r5 returns the old value.
    fetch(32'h00A5_0020, 32'h5555, 1'b0);
    RegWrite = 1; aluResult = 32'h1234; ALUSrcA = 1;
    step();
    check("r5_first_old", aluParamData1, 32'h0);
    step();
    check("r5_old", aluParamData1, 32'h5555);
    clr();
    step();
    ALUSrcA = 1;
    #1;
    check("r5_new_a", aluParamData1, 32'h1234);
    check("r5_new_b", aluParamData2, 32'h1234);

    // MDR keeps the last read word despite junk on mem_rdata with no request.
    clr();
    RegWrite = 1; MemToReg = 2'b01;
    step();
    clr();
    step();
    ALUSrcA = 1;
    #1;
    check("mdr_wb", aluParamData1, 32'h00A5_0020);

    // Store held through WAIT while the controls wander; read+write counts as a write.
    clr();
    aluResult = 32'h0123;
    step();
    clr();
    MemWrite = 1; MemRead = 1; IorD = 1; aluResult = 32'h0999;
    #1;
    check("sw_req", {31'b0, mem_req}, 32'h1);
    check("sw_we", {31'b0, mem_we}, 32'h1);
    check("sw_addr", {16'b0, mem_addr}, 32'h0123);
    check("sw_wdata", mem_wdata, 32'h00A5_0020);
    step();
    MemWrite = 0; IorD = 0;
    #1;
    check("sww_addr", {16'b0, mem_addr}, 32'h0123);
    check("sww_we", {31'b0, mem_we}, 32'h1);
    check("sww_wdata", mem_wdata, 32'h00A5_0020);
    check("sww_stall", {31'b0, stall}, 32'h1);
    step();
    mem_ready = 1;
    #1;
    check("swr_addr", {16'b0, mem_addr}, 32'h0123);
    check("swr_nostall", {31'b0, stall}, 32'h0);
    step();
    clr();
    #1;
    check("sw_done", {31'b0, mem_req}, 32'h0);
    check("sw_cnt", {28'b0, stall_cnt}, 32'd2);

    // Counter saturation.
    MemRead = 1;
    repeat (20) step();
    check("cnt_sat", {28'b0, stall_cnt}, 32'hF);
    mem_ready = 1;
    step();
    clr();
    #1;
    check("cnt_sat_hold", {28'b0, stall_cnt}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
